// File: rtl/cnn_result_tx.sv
// -----------------------------------------------------------------------------
// cnn_result_tx
// Output-side transmitter for the CNN layer. Result words arrive from the
// convolution datapath as single-cycle strobes (no backpressure), are buffered
// in a small FIFO and leave the accelerator as an AXI4-Stream master toward
// DMA. TLAST marks the final beat of each feature-map frame.
//
// Ports:
//   S_AXIS_ACLK    in   clock for the whole block
//   S_AXIS_ARESET  in   synchronous active-high reset
//   Res_Valid      in   one-cycle strobe, Res_Data holds a valid result
//   Res_Data       in   result word from the datapath
//   M_AXIS_TVALID  out  stream beat valid
//   M_AXIS_TDATA   out  stream data
//   M_AXIS_TLAST   out  last beat of a frame
//   M_AXIS_TREADY  in   downstream ready
//   Overflow       out  sticky, a result was dropped on a full FIFO
//   Frame_Done     out  one-cycle pulse after the TLAST beat handshakes
//   Busy           out  FIFO non-empty or a beat is being presented
// -----------------------------------------------------------------------------
module cnn_result_tx #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 100
) (
    input  logic              S_AXIS_ACLK,
    input  logic              S_AXIS_ARESET,
    input  logic              Res_Valid,
    input  logic [DATA_W-1:0] Res_Data,
    output logic              M_AXIS_TVALID,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    output logic              Overflow,
    output logic              Frame_Done,
    output logic              Busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LAST
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [BW-1:0]     r_beat;
    logic              r_tvalid;
    logic              r_tlast;
    logic [DATA_W-1:0] r_tdata;
    logic              r_overflow;
    logic              r_frameDone;

    logic w_fifoEmpty;
    logic w_fifoFull;
    logic w_handshake;
    logic w_load;
    logic w_push;
    logic w_beatIsLast;

    assign w_fifoEmpty  = (r_count == '0);
    assign w_fifoFull   = (r_count == DEPTH_C);
    assign w_handshake  = r_tvalid & M_AXIS_TREADY;
    // The output register refills whenever it is empty or being drained this
    // cycle, so TVALID only ever depends on registered state.
    assign w_load       = ~w_fifoEmpty & (~r_tvalid | M_AXIS_TREADY);
    // A full FIFO can still take a word when a pop frees a slot in the same cycle.
    assign w_push       = Res_Valid & (~w_fifoFull | w_load);
    assign w_beatIsLast = (r_beat == LAST_IDX);

    // FIFO storage; emptiness is governed by the pointers, so no reset needed.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESET && w_push) begin
            r_mem[r_wptr] <= Res_Data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_load) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (Res_Valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output FSM: owns the AXI output register and the frame beat counter.
    // TLAST is decided when a word is loaded, so it is stable with TDATA.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_state     <= IDLE;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_beat      <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_handshake && (r_state == LAST);
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= r_mem[r_rptr];
                r_tlast  <= w_beatIsLast;
                r_beat   <= w_beatIsLast ? '0 : r_beat + 1'b1;
                r_state  <= w_beatIsLast ? LAST : SEND;
            end else if (w_handshake) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_state  <= IDLE;
            end
        end
    end

    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TLAST  = r_tlast;
    assign Overflow      = r_overflow;
    assign Frame_Done    = r_frameDone;
    assign Busy          = ~w_fifoEmpty | r_tvalid;

endmodule

// File: tb/tb_cnn_result_tx.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cnn_result_tx, built with a 4-entry FIFO and a
// 4-beat frame so that wrap, full and overflow corners are reached quickly.
// Expected beats are queued as strobes are driven; a negedge monitor pops and
// compares every handshake and also checks Frame_Done and AXI stability.
// -----------------------------------------------------------------------------
module tb_cnn_result_tx;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int FLEN   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              resValid;
    logic [DATA_W-1:0] resData;
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tready;
    logic              overflow;
    logic              frameDone;
    logic              busy;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             expQ[$];
    beat_t             monBeat;
    int                errors = 0;
    int                checks = 0;
    int                modelBeat = 0;
    int                fdCount = 0;
    bit                monEn = 1'b0;
    logic              expFd = 1'b0;
    bit                prevStall = 1'b0;
    logic [DATA_W-1:0] prevData;
    logic              prevLast;

    always #5 clk = ~clk;

    cnn_result_tx #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(DEPTH),
        .FRAME_LEN (FLEN)
    ) u_dut (
        .S_AXIS_ACLK  (clk),
        .S_AXIS_ARESET(rst),
        .Res_Valid    (resValid),
        .Res_Data     (resData),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TLAST (tlast),
        .M_AXIS_TREADY(tready),
        .Overflow     (overflow),
        .Frame_Done   (frameDone),
        .Busy         (busy)
    );

    // Scoreboard monitor: compares each handshaking beat with the queue head,
    // expects Frame_Done the cycle after a TLAST handshake, and requires a
    // stalled beat to stay unchanged.
    always @(negedge clk) begin
        if (!monEn) begin
            prevStall = 1'b0;
            expFd     = 1'b0;
        end else begin
            checks++;
            if (frameDone !== expFd) begin
                errors++;
                $display("[TB] FAIL frame_done: got %b expected %b", frameDone, expFd);
            end
            if (frameDone === 1'b1) fdCount++;
            if (prevStall) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== prevData || tlast !== prevLast) begin
                    errors++;
                    $display("[TB] FAIL stall_stable: got v=%b d=%0h l=%b expected v=1 d=%0h l=%b",
                             tvalid, tdata, tlast, prevData, prevLast);
                end
            end
            expFd = 1'b0;
            if (tvalid === 1'b1 && tready === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got data %0h expected no beat", tdata);
                end else begin
                    monBeat = expQ.pop_front();
                    if (tdata !== monBeat.data) begin
                        errors++;
                        $display("[TB] FAIL tdata: got %0h expected %0h", tdata, monBeat.data);
                    end
                    checks++;
                    if (tlast !== monBeat.last) begin
                        errors++;
                        $display("[TB] FAIL tlast (data %0h): got %b expected %b",
                                 monBeat.data, tlast, monBeat.last);
                    end
                    expFd = monBeat.last;
                end
            end
            prevStall = (tvalid === 1'b1 && tready === 1'b0);
            prevData  = tdata;
            prevLast  = tlast;
        end
    end

    task automatic push_exp(input logic [DATA_W-1:0] d);
        beat_t b;
        b.data = d;
        b.last = (modelBeat == FLEN - 1);
        expQ.push_back(b);
        modelBeat = (modelBeat == FLEN - 1) ? 0 : modelBeat + 1;
    endtask

    task automatic drive_word(input logic [DATA_W-1:0] d, input bit accept);
        resValid = 1'b1;
        resData  = d;
        if (accept) push_exp(d);
        @(posedge clk);
        #1;
        resValid = 1'b0;
    endtask

    task automatic do_reset();
        monEn    = 1'b0;
        rst      = 1'b1;
        resValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        modelBeat = 0;
        monEn = 1'b1;
    endtask

    task automatic wait_drain(input int maxCyc, input string name);
        int n = 0;
        while ((expQ.size() != 0 || busy !== 1'b0) && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_%s: got %0d beats pending busy=%b expected 0 pending busy=0",
                     name, expQ.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tready  = 1'b1;
        resData = 32'hDEAD_BEEF;
        do_reset();
        @(negedge clk);
        checks++; if (tvalid    !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", tvalid); end
        checks++; if (tdata     !== '0)   begin errors++; $display("[TB] FAIL reset_tdata: got %0h expected 0", tdata); end
        checks++; if (tlast     !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b expected 0", tlast); end
        checks++; if (overflow  !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frameDone); end
        checks++; if (busy      !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1;
    endtask

    // Strobes 1..5 back to back; TVALID must first appear two cycles after
    // the first strobe carrying word 1.
    task automatic test_basic();
        logic expV;
        tready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            resValid = 1'b1;
            resData  = DATA_W'(i);
            push_exp(DATA_W'(i));
            @(negedge clk);
            expV = (i >= 3);
            checks++;
            if (tvalid !== expV) begin
                errors++;
                $display("[TB] FAIL latency_tvalid (cycle %0d): got %b expected %b", i - 1, tvalid, expV);
            end
            if (i == 3) begin
                checks++;
                if (tdata !== 32'd1) begin
                    errors++;
                    $display("[TB] FAIL latency_tdata: got %0h expected 1", tdata);
                end
            end
            @(posedge clk);
            #1;
        end
        resValid = 1'b0;
        wait_drain(10, "basic");
    endtask

    task automatic test_frames();
        int fd0;
        do_reset();
        tready = 1'b1;
        fd0 = fdCount;
        for (int d = 10; d <= 17; d++) drive_word(DATA_W'(d), 1'b1);
        wait_drain(12, "frames");
        checks++;
        if (fdCount - fd0 != 2) begin
            errors++;
            $display("[TB] FAIL frame_done_count: got %0d expected 2", fdCount - fd0);
        end
    endtask

    // Continues after the wrapped frame, so these words are beats 0..2.
    task automatic test_stall();
        tready = 1'b0;
        drive_word(32'd20, 1'b1);
        drive_word(32'd21, 1'b1);
        drive_word(32'd22, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'd20) begin
            errors++;
            $display("[TB] FAIL stall_head: got v=%b d=%0h expected v=1 d=20", tvalid, tdata);
        end
        @(posedge clk);
        #1;
        tready = 1'b1;
        wait_drain(10, "stall");
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_overflow: got %b expected 0", overflow);
        end
    endtask

    // Output register takes word 1, FIFO holds 2..5, word 6 is dropped.
    task automatic test_overflow();
        do_reset();
        tready = 1'b0;
        for (int d = 1; d <= 5; d++) drive_word(DATA_W'(d), 1'b1);
        drive_word(32'd6, 1'b0);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || tdata !== 32'd1) begin
            errors++;
            $display("[TB] FAIL overflow_set: got ovf=%b d=%0h expected ovf=1 d=1", overflow, tdata);
        end
        @(posedge clk);
        #1;
        tready = 1'b1;
        wait_drain(12, "overflow");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
        end
    endtask

    // Full FIFO, but a handshake in the same cycle frees a slot for word 6.
    task automatic test_full_simultaneous();
        do_reset();
        tready = 1'b0;
        for (int d = 1; d <= 5; d++) drive_word(DATA_W'(d), 1'b1);
        tready = 1'b1;
        drive_word(32'd6, 1'b1);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_push_overflow: got %b expected 0", overflow);
        end
        @(posedge clk);
        #1;
        wait_drain(12, "full_simultaneous");
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_drain_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_reset_midframe();
        int fd0;
        do_reset();
        tready = 1'b0;
        for (int d = 30; d <= 33; d++) drive_word(DATA_W'(d), 1'b1);
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midframe_loaded: got v=%b busy=%b expected v=1 busy=1", tvalid, busy);
        end
        @(posedge clk);
        #1;
        monEn = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        modelBeat = 0;
        monEn = 1'b1;
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || tdata !== '0 || tlast !== 1'b0 || overflow !== 1'b0 ||
            frameDone !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got v=%b d=%0h l=%b ovf=%b fd=%b busy=%b expected all 0",
                     tvalid, tdata, tlast, overflow, frameDone, busy);
        end
        @(posedge clk);
        #1;
        tready = 1'b1;
        fd0 = fdCount;
        for (int d = 40; d <= 43; d++) drive_word(DATA_W'(d), 1'b1);
        wait_drain(10, "after_reset");
        checks++;
        if (fdCount - fd0 != 1) begin
            errors++;
            $display("[TB] FAIL fresh_frame_done: got %0d expected 1", fdCount - fd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        resValid = 1'b0;
        resData  = '0;
        tready   = 1'b0;
        test_reset();
        test_basic();
        test_frames();
        test_stall();
        test_overflow();
        test_full_simultaneous();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
